// File: rtl/apb_pkg.sv
// Shared types and default sizing for the two-requester APB master.
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } apb_state_e;

   localparam int DEF_ADDR_W  = 5;
   localparam int DEF_DATA_W  = 32;
   localparam int DEF_TIMEOUT = 15;
   localparam int CNT_W       = 8;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter: a lone request wins outright, a tie goes to
// whichever requester was not granted last.
module rr_arbiter_2 (
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);

   always_comb begin
      grant_o = valid_i;
      if (valid_i == 2'b11) begin
         grant_o = last_grant_i ? 2'b01 : 2'b10;
      end
   end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by two requesters: round-robin accept, SETUP/ACCESS
// sequencing, PREADY wait with timeout abort, per-requester result return.
module apb_master_arbiter
   import apb_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic              PCLK,
   input  logic              PRESETn,
   input  logic              req0_valid,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic              req0_ready,
   output logic              req0_done,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_err,
   input  logic              req1_valid,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic              req1_ready,
   output logic              req1_done,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_err,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY
);

   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

   apb_state_e              state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    last_grant_q, last_grant_d;
   logic                    owner_q, owner_d;
   logic                    pwrite_q, pwrite_d;
   logic [ADDR_W-1:0]       paddr_q, paddr_d;
   logic [DATA_W-1:0]       pwdata_q, pwdata_d;
   logic [1:0]              done_q, done_d;
   logic [1:0]              err_q, err_d;
   logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
   logic [1:0]              grant;
   logic [CNT_W-1:0]        cnt_inc;

   rr_arbiter_2 u_arb (
      .valid_i      ({req1_valid, req0_valid}),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         done_q       <= '0;
         err_q        <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         pwrite_q     <= pwrite_d;
         paddr_q      <= paddr_d;
         pwdata_q     <= pwdata_d;
         done_q       <= done_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      pwrite_d     = pwrite_q;
      paddr_d      = paddr_q;
      pwdata_d     = pwdata_q;
      done_d       = 2'b00;
      err_d        = 2'b00;
      rdata_d      = rdata_q;
      case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               owner_d      = grant[1];
               last_grant_d = grant[1];
               pwrite_d     = grant[1] ? req1_write : req0_write;
               paddr_d      = grant[1] ? req1_addr  : req0_addr;
               pwdata_d     = grant[1] ? req1_wdata : req0_wdata;
               state_d      = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (PREADY) begin
               done_d[owner_q] = 1'b1;
               if (!pwrite_q) begin
                  rdata_d[owner_q] = PRDATA;
               end
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
               // Abort after TIMEOUT consecutive wait cycles; read data is left untouched.
               if (cnt_inc == TIMEOUT_C) begin
                  done_d[owner_q] = 1'b1;
                  err_d[owner_q]  = 1'b1;
                  state_d         = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      PSEL       = 1'b0;
      PENABLE    = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (state_q)
         IDLE: begin
            req0_ready = grant[0];
            req1_ready = grant[1];
         end
         SETUP: PSEL = 1'b1;
         ACCESS: begin
            PSEL    = 1'b1;
            PENABLE = 1'b1;
         end
         default: ;
      endcase
   end

   assign PWRITE     = pwrite_q;
   assign PADDR      = paddr_q;
   assign PWDATA     = pwdata_q;
   assign req0_done  = done_q[0];
   assign req1_done  = done_q[1];
   assign req0_err   = err_q[0];
   assign req1_err   = err_q[1];
   assign req0_rdata = rdata_q[0];
   assign req1_rdata = rdata_q[1];

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter: directed scenarios plus random
// transfers checked against a transaction-level model of grant and completion.
module tb_apb_master_arbiter;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          PCLK, PRESETn;
   logic          req0_valid, req0_write, req0_ready, req0_done, req0_err;
   logic [AW-1:0] req0_addr;
   logic [DW-1:0] req0_wdata, req0_rdata;
   logic          req1_valid, req1_write, req1_ready, req1_done, req1_err;
   logic [AW-1:0] req1_addr;
   logic [DW-1:0] req1_wdata, req1_rdata;
   logic          PSEL, PENABLE, PWRITE, PREADY;
   logic [AW-1:0] PADDR;
   logic [DW-1:0] PWDATA, PRDATA;

   apb_master_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_done(req0_done),
      .req0_rdata(req0_rdata), .req0_err(req0_err),
      .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_done(req1_done),
      .req1_rdata(req1_rdata), .req1_err(req1_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
      .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   int          n_vec = 0;
   int          n_bad = 0;
   // Reference model: who won last, what each requester should see as rdata,
   // and the completion expected in the next IDLE cycle.
   int          m_last;
   logic [DW-1:0] m_rdata [2];
   bit          pend;
   int          pend_owner;
   bit          pend_err;

   task automatic model_reset();
      m_last     = 1;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
      pend       = 1'b0;
   endtask

   task automatic scramble();
      req0_valid = 1'($urandom);
      req1_valid = 1'($urandom);
      req0_write = 1'($urandom);
      req1_write = 1'($urandom);
      req0_addr  = AW'($urandom);
      req1_addr  = AW'($urandom);
      req0_wdata = $urandom;
      req1_wdata = $urandom;
      PREADY     = 1'($urandom);
      PRDATA     = $urandom;
   endtask

   // Checks the completion slot of the current (IDLE) cycle against the model.
   task automatic idle_slot();
      logic [1:0] e_done, e_err;
      e_done = pend ? ((pend_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
      e_err  = (pend && pend_err) ? e_done : 2'b00;
      n_vec++;
      if ({req1_done, req0_done, req1_err, req0_err, PSEL, PENABLE} !== {e_done, e_err, 2'b00}) begin
         n_bad++;
         $display("FAIL done_slot: got done=%b err=%b psel=%b pen=%b, expected done=%b err=%b psel=0 pen=0",
                  {req1_done, req0_done}, {req1_err, req0_err}, PSEL, PENABLE, e_done, e_err);
      end
      n_vec++;
      if (req0_rdata !== m_rdata[0] || req1_rdata !== m_rdata[1]) begin
         n_bad++;
         $display("FAIL rdata: got %h/%h expected %h/%h", req0_rdata, req1_rdata, m_rdata[0], m_rdata[1]);
      end
      pend = 1'b0;
   endtask

   task automatic idle_cycle();
      idle_slot();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      PREADY     = 1'($urandom);
      #1;
      n_vec++;
      if ({req1_ready, req0_ready} !== 2'b00) begin
         n_bad++;
         $display("FAIL idle_ready: got %b expected 00", {req1_ready, req0_ready});
      end
      @(posedge PCLK); @(negedge PCLK);
   endtask

   // One transfer starting at the negedge of an IDLE cycle; returns at the
   // negedge of the completion cycle (or after a reset injected in ACCESS cycle rst_k).
   task automatic do_xfer(input bit v0, input bit v1, input bit wr0, input bit wr1,
                          input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                          input logic [DW-1:0] prd, input int waits, input int rst_k);
      int            winner, last_k;
      bit            e_wr;
      logic [AW-1:0] e_a;
      logic [DW-1:0] e_d;
      idle_slot();
      req0_valid = v0; req1_valid = v1;
      req0_write = wr0; req1_write = wr1;
      req0_addr = a0; req1_addr = a1;
      req0_wdata = d0; req1_wdata = d1;
      PREADY = 1'($urandom);
      #1;
      winner = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v1 ? 1 : 0);
      n_vec++;
      if ({req1_ready, req0_ready} !== ((winner == 1) ? 2'b10 : 2'b01)) begin
         n_bad++;
         $display("FAIL grant: got ready=%b expected winner %0d", {req1_ready, req0_ready}, winner);
      end
      m_last = winner;
      e_wr = (winner == 1) ? wr1 : wr0;
      e_a  = (winner == 1) ? a1 : a0;
      e_d  = (winner == 1) ? d1 : d0;
      @(posedge PCLK); @(negedge PCLK);
      scramble();
      #1;
      n_vec++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req1_ready, req0_ready, req1_done, req0_done}
          !== {2'b10, e_wr, e_a, e_d, 4'b0000}) begin
         n_bad++;
         $display("FAIL setup: got sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b done=%b expected sel=1 en=0 wr=%b addr=%h wd=%h rdy=00 done=00",
                  PSEL, PENABLE, PWRITE, PADDR, PWDATA, {req1_ready, req0_ready}, {req1_done, req0_done}, e_wr, e_a, e_d);
      end
      last_k = (waits < TO) ? waits : TO - 1;
      for (int k = 0; k <= last_k; k++) begin
         @(posedge PCLK); @(negedge PCLK);
         scramble();
         PREADY = (k == waits);
         if (k == waits) PRDATA = prd;
         if (k == rst_k) begin
            PRESETn = 1'b0;
            #1;
            n_vec++;
            if ({PSEL, PENABLE, req1_done, req0_done, req1_err, req0_err} !== 6'b0 ||
                req0_rdata !== '0 || req1_rdata !== '0) begin
               n_bad++;
               $display("FAIL reset_mid: got sel=%b en=%b done=%b err=%b expected all 0",
                        PSEL, PENABLE, {req1_done, req0_done}, {req1_err, req0_err});
            end
            model_reset();
            req0_valid = 1'b0; req1_valid = 1'b0;
            @(posedge PCLK); @(negedge PCLK);
            PRESETn = 1'b1;
            return;
         end
         #1;
         n_vec++;
         if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req1_ready, req0_ready, req1_done, req0_done}
             !== {2'b11, e_wr, e_a, e_d, 4'b0000}) begin
            n_bad++;
            $display("FAIL access[%0d]: got sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b done=%b expected sel=1 en=1 wr=%b addr=%h wd=%h",
                     k, PSEL, PENABLE, PWRITE, PADDR, PWDATA, {req1_ready, req0_ready}, {req1_done, req0_done}, e_wr, e_a, e_d);
         end
      end
      @(posedge PCLK); @(negedge PCLK);
      req0_valid = 1'b0; req1_valid = 1'b0; PREADY = 1'b0;
      pend       = 1'b1;
      pend_owner = winner;
      pend_err   = (waits >= TO);
      if (!e_wr && !pend_err) m_rdata[winner] = prd;
      $display("xfer owner=%0d wr=%0b addr=%h waits=%0d err=%0b", winner, e_wr, e_a, waits, pend_err);
   endtask

   task automatic test_reset();
      PRESETn = 1'b0;
      req0_valid = 0; req1_valid = 0; req0_write = 0; req1_write = 0;
      req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
      PREADY = 0; PRDATA = '0;
      model_reset();
      repeat (3) @(negedge PCLK);
      n_vec++;
      if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, req1_ready, req0_ready, req1_done, req0_done,
           req1_err, req0_err, req0_rdata, req1_rdata} !== '0) begin
         n_bad++;
         $display("FAIL reset_state: sel=%b en=%b wr=%b addr=%h wd=%h rdy=%b done=%b err=%b rd=%h/%h expected all 0",
                  PSEL, PENABLE, PWRITE, PADDR, PWDATA, {req1_ready, req0_ready}, {req1_done, req0_done},
                  {req1_err, req0_err}, req0_rdata, req1_rdata);
      end
      PRESETn = 1'b1;
      @(negedge PCLK);
      $display("reset checked");
   endtask

   task automatic test_zero_wait_write();
      do_xfer(1, 0, 1, 0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 0, -1);
      idle_cycle();
      idle_cycle();
   endtask

   task automatic test_wait_read();
      do_xfer(0, 1, 0, 0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h12345678, 3, -1);
      idle_cycle();
   endtask

   task automatic test_alternate();
      for (int i = 0; i < 4; i++) begin
         do_xfer(1, 1, 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
                 $urandom, $urandom, $urandom, 0, -1);
      end
      idle_cycle();
   endtask

   task automatic test_timeout();
      do_xfer(1, 0, 0, 0, 5'd9, 5'd0, 32'h0, 32'h0, 32'hBAD0BAD0, TO + 4, -1);
      do_xfer(1, 0, 0, 0, 5'd9, 5'd0, 32'h0, 32'h0, 32'hC0FFEE00, 1, -1);
      idle_cycle();
   endtask

   task automatic test_busy_pulse();
      do_xfer(0, 1, 0, 1, 5'd0, 5'd17, 32'h0, 32'h55AA55AA, 32'h0, 2, -1);
      idle_cycle();
      idle_cycle();
   endtask

   task automatic test_reset_mid();
      do_xfer(0, 1, 0, 0, 5'd1, 5'd2, 32'h0, 32'h0, 32'h0, 6, 1);
      idle_cycle();
      do_xfer(1, 1, 0, 0, 5'd4, 5'd6, 32'h0, 32'h0, 32'h0BADCAFE, 0, -1);
      idle_cycle();
   endtask

   task automatic test_random();
      int v, w;
      for (int i = 0; i < 60; i++) begin
         v = $urandom_range(1, 3);
         w = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 4);
         do_xfer(v[0], v[1], 1'($urandom), 1'($urandom), AW'($urandom), AW'($urandom),
                 $urandom, $urandom, $urandom, w, -1);
         if ($urandom_range(0, 3) == 0) idle_cycle();
      end
      idle_cycle();
   endtask

   initial begin
      test_reset();
      test_zero_wait_write();
      test_wait_read();
      test_alternate();
      test_timeout();
      test_busy_pulse();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
Two-requester APB master that shares one APB bus between two internal requesters (e.g. core load/store port and debug port). It performs round-robin arbitration, runs the APB SETUP/ACCESS protocol toward peripheral slaves such as the GPIO block, waits on PREADY, and returns read data and status to the winning requester. A wait-state timeout keeps a hung slave from locking the bus.

Parameters:
ADDR_W, 5, APB address width (matches peripheral PADDR)
DATA_W, 32, APB data width
TIMEOUT, 15, max ACCESS cycles without PREADY before abort (1..255)

Ports:
PCLK  in  1  bus clock, all state on rising edge
PRESETn  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a transfer pending
req0_write  in  1  1 = write, 0 = read
req0_addr  in  ADDR_W  transfer address
req0_wdata  in  DATA_W  write data
req0_ready  out  1  accept strobe; transfer taken when valid&&ready at PCLK edge
req0_done  out  1  one-cycle completion pulse
req0_rdata  out  DATA_W  read data, valid with req0_done
req0_err  out  1  timeout flag, valid with req0_done
req1_* (valid, write, addr, wdata, ready, done, rdata, err)  same as req0_*
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PRDATA  in  DATA_W  APB read data
PREADY  in  1  slave ready

Behaviour:
- Reset (PRESETn=0, async): state IDLE; PSEL, PENABLE, PWRITE=0; PADDR, PWDATA=0; all req*_ready/done/err=0; req*_rdata=0; wait counter=0; last_grant=1 (requester 0 wins first contest).
- States: IDLE, SETUP, ACCESS.
- IDLE: reqN_ready is combinational = grant for N; only one ready high at a time. Grant: if one valid, that one; if both, the one != last_grant. On accept edge: latch write/addr/wdata and owner, update last_grant, go SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA = latched values. Next ACCESS, counter cleared.
- ACCESS: PSEL=1, PENABLE=1, address/control/data held stable. PREADY=1 -> capture PRDATA (reads only; writes leave rdata unchanged), pulse owner done with err=0, go IDLE. PREADY=0 -> counter++; counter reaching TIMEOUT -> done with err=1, rdata unchanged, go IDLE.
- Outside SETUP/ACCESS, PSEL=PENABLE=0; PADDR/PWDATA/PWRITE keep last values.
- Minimum latency: accept at edge T, SETUP in cycle T+1, ACCESS T+2, done pulse in cycle T+3 (registered), IDLE in T+3 so next accept at edge T+3 at earliest; 3 cycles per zero-wait transfer.
- Non-owner done/err never asserted. ready never asserted outside IDLE.
- Request deasserted before accept: no transfer, no pulse. Inputs after accept are ignored.
- Reset mid-transfer: transfer dropped, no done pulse, bus idle immediately.
- PREADY in IDLE/SETUP ignored.

Decomposition:
- Shared package apb_pkg: state enum {IDLE, SETUP, ACCESS}, default ADDR_W/DATA_W constants, TIMEOUT default.
- Sub-module rr_arbiter_2: valid[1:0] + last_grant -> one-hot grant; instantiated once.

Test Plan:
- req0 write addr 5 data 0xDEADBEEF, PREADY tied 1 -> PSEL cycle T+1 with PENABLE=0, PENABLE=1 cycle T+2, req0_done=1 err=0 cycle T+3, req1_done stays 0.
- req1 read addr 3, PREADY low 3 ACCESS cycles then high with PRDATA=0x12345678 -> PADDR/PWRITE stable throughout, req1_rdata=0x12345678 with req1_done, total 6 cycles.
- Both valid continuously from reset -> grants alternate 0,1,0,1; each done pulses only its owner.
- PREADY held 0 -> after 15 ACCESS cycles, done with err=1, rdata unchanged, bus returns idle, next request serviced normally.
- PRESETn asserted during ACCESS -> PSEL/PENABLE drop same cycle, no done pulse; after release req0 wins first.
- req0_valid pulsed one cycle while busy with req1 -> never accepted, no req0_done.
